// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel sequencing interface.
// The phase encoding is common with the pixel state controller.
package pixel_pkg;

  typedef enum logic [2:0] {
    ERASE   = 3'd0,
    EXPOSE  = 3'd1,
    CONVERT = 3'd2,
    READ1   = 3'd3,
    READ2   = 3'd4,
    IDLE    = 3'd5
  } phase_t;

  typedef enum logic [1:0] {
    CAP_WAIT  = 2'd0,
    CAP_COUNT = 2'd1,
    CAP_HOLD  = 2'd2
  } cap_state_t;

  localparam int c_read    = 5;
  localparam int c_convert = 255;

  function automatic int col_w(input int n_cols);
    return (n_cols > 1) ? $clog2(n_cols) : 1;
  endfunction

endpackage

// File: rtl/pixel_readout_if.sv
// Pixel output stream bundle between the readout and its sink.
interface pixel_readout_if #(
  parameter int DATA_W = 8,
  parameter int COL_W  = 1
);
  // Handshake: a beat transfers on a clock edge where out_valid and out_ready
  // are both 1. Once out_valid rises, it and out_data/out_row/out_col/out_last
  // hold stable until that transfer; out_ready may change freely.
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_row;
  logic [COL_W-1:0]  out_col;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/pixel_row_buffer.sv
// Two-entry ping-pong row storage with in-order column-by-column drain.
module pixel_row_buffer
  import pixel_pkg::*;
#(
  parameter int N_COLS = 2,
  parameter int DATA_W = 8,
  parameter int COL_W  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cap_en,
  input  logic                     cap_row,
  input  logic [N_COLS*DATA_W-1:0] cap_data,
  output logic                     cap_free,
  pixel_readout_if.master          stream
);

  logic [N_COLS*DATA_W-1:0] mem [2];
  logic [1:0]               valid_q;
  logic [1:0]               row_q;
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [COL_W-1:0]         col_q;
  logic                     xfer;
  logic                     last_col;
  logic                     free_now;

  assign last_col = (col_q == COL_W'(N_COLS - 1));
  assign xfer     = valid_q[rd_ptr] & stream.out_ready;
  assign free_now = xfer & last_col;
  // The entry being drained counts as free on the beat its last column leaves.
  assign cap_free = ~valid_q[wr_ptr] | (free_now & (rd_ptr == wr_ptr));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      row_q   <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      col_q   <= '0;
    end else begin
      if (xfer) begin
        if (last_col) begin
          col_q           <= '0;
          valid_q[rd_ptr] <= 1'b0;
          rd_ptr          <= ~rd_ptr;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      // Placed after the free so a same-cycle recapture keeps the flag set.
      if (cap_en) begin
        valid_q[wr_ptr] <= 1'b1;
        row_q[wr_ptr]   <= cap_row;
        wr_ptr          <= ~wr_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_en) mem[wr_ptr] <= cap_data;
  end

  assign stream.out_valid = valid_q[rd_ptr];
  assign stream.out_data  = valid_q[rd_ptr] ? mem[rd_ptr][col_q*DATA_W +: DATA_W] : '0;
  assign stream.out_row   = valid_q[rd_ptr] & row_q[rd_ptr];
  assign stream.out_col   = col_q;
  assign stream.out_last  = valid_q[rd_ptr] & row_q[rd_ptr] & last_col;

endmodule

// File: rtl/pixel_readout.sv
// Readout end of the pixel sequencer: ramp generation, frame counting,
// read-phase capture FSM and error flags, feeding the row buffer stream.
module pixel_readout
  import pixel_pkg::*;
#(
  parameter int N_COLS     = 2,
  parameter int DATA_W     = 8,
  parameter int SAMPLE_DLY = 2,
  parameter int FRAME_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     erase,
  input  logic                     expose,
  input  logic                     convert,
  input  logic                     read1,
  input  logic                     read2,
  input  logic [N_COLS*DATA_W-1:0] pix_data,
  output logic                     dac_en,
  output logic [DATA_W-1:0]        dac_code,
  output logic [FRAME_W-1:0]       frame_id,
  output logic                     overflow,
  output logic                     proto_err,
  output cap_state_t               dbg_state,
  output phase_t                   dbg_phase,
  pixel_readout_if.master          stream
);

  localparam int COL_W = col_w(N_COLS);
  localparam int CNT_W = $clog2(SAMPLE_DLY + 1);

  cap_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             row_q, row_d;
  logic             erase_q;
  logic             sel_read;
  logic             cap_en;
  logic             cap_free;
  logic             set_proto;
  logic             set_ovf;

  // Ramp restarts at 0 on the first convert cycle and saturates at full scale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac_en   <= 1'b0;
      dac_code <= '0;
      erase_q  <= 1'b0;
      frame_id <= '0;
    end else begin
      dac_en  <= convert;
      erase_q <= erase;
      if (!convert || !dac_en) dac_code <= '0;
      else if (dac_code != '1) dac_code <= dac_code + 1'b1;
      if (erase && !erase_q) frame_id <= frame_id + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CAP_WAIT;
      cnt_q     <= '0;
      row_q     <= 1'b0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      if (set_ovf)   overflow  <= 1'b1;
      if (set_proto) proto_err <= 1'b1;
    end
  end

  assign sel_read = row_q ? read2 : read1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    cap_en    = 1'b0;
    set_proto = 1'b0;
    set_ovf   = 1'b0;
    case (state_q)
      CAP_WAIT: begin
        if (read1 ^ read2) begin
          row_d   = read2;
          cnt_d   = CNT_W'(1);
          state_d = CAP_COUNT;
        end else if (read1 && read2) begin
          set_proto = 1'b1;
          state_d   = CAP_HOLD;
        end
      end
      CAP_COUNT: begin
        if (!sel_read) begin
          set_proto = 1'b1;
          state_d   = CAP_WAIT;
        end else if (cnt_q == CNT_W'(SAMPLE_DLY)) begin
          if (cap_free) cap_en  = 1'b1;
          else          set_ovf = 1'b1;
          state_d = CAP_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAP_HOLD: begin
        if (!read1 && !read2) state_d = CAP_WAIT;
      end
      default: state_d = CAP_WAIT;
    endcase
  end

  always_comb begin
    dbg_phase = IDLE;
    if (read2)        dbg_phase = READ2;
    else if (read1)   dbg_phase = READ1;
    else if (convert) dbg_phase = CONVERT;
    else if (expose)  dbg_phase = EXPOSE;
    else if (erase)   dbg_phase = ERASE;
  end

  assign dbg_state = state_q;

  pixel_row_buffer #(
    .N_COLS (N_COLS),
    .DATA_W (DATA_W),
    .COL_W  (COL_W)
  ) u_row_buffer (
    .clk      (clk),
    .reset    (reset),
    .cap_en   (cap_en),
    .cap_row  (row_q),
    .cap_data (pix_data),
    .cap_free (cap_free),
    .stream   (stream)
  );

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: stream order, ramp, overflow, protocol
// errors and asynchronous reset mid-drain.
module tb_pixel_readout;
  import pixel_pkg::*;

  localparam int W = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        erase = 1'b0;
  logic        expose = 1'b0;
  logic        convert = 1'b0;
  logic        read1 = 1'b0;
  logic        read2 = 1'b0;
  logic [15:0] pix_data = '0;
  logic        dac_en;
  logic [7:0]  dac_code;
  logic [7:0]  frame_id;
  logic        overflow;
  logic        proto_err;
  cap_state_t  dbg_state;
  phase_t      dbg_phase;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  pixel_readout_if #(.DATA_W(8), .COL_W(1)) stream_if ();

  pixel_readout #(
    .N_COLS(2), .DATA_W(8), .SAMPLE_DLY(2), .FRAME_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .erase     (erase),
    .expose    (expose),
    .convert   (convert),
    .read1     (read1),
    .read2     (read2),
    .pix_data  (pix_data),
    .dac_en    (dac_en),
    .dac_code  (dac_code),
    .frame_id  (frame_id),
    .overflow  (overflow),
    .proto_err (proto_err),
    .dbg_state (dbg_state),
    .dbg_phase (dbg_phase),
    .stream    (stream_if)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Transfers are recorded mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (!reset && stream_if.out_valid && stream_if.out_ready)
      got_q.push_back({stream_if.out_row, stream_if.out_col,
                       stream_if.out_last, stream_if.out_data});
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    read1 = 1'b0; read2 = 1'b0; erase = 1'b0; expose = 1'b0; convert = 1'b0;
    step(2);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic read_pulse(input bit row, input logic [15:0] data, input int len);
    pix_data = data;
    if (row) read2 = 1'b1;
    else     read1 = 1'b1;
    step(len);
    read1 = 1'b0;
    read2 = 1'b0;
    step(1);
  endtask

  task automatic erase_pulse();
    erase = 1'b1;
    step(2);
    erase = 1'b0;
    step(1);
  endtask

  function automatic logic [W-1:0] beat(input bit row, input bit col, input bit last,
                                        input logic [7:0] data);
    return {row, col, last, data};
  endfunction

  // Scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stream(input string tag);
    logic [W-1:0] e;
    logic [W-1:0] g;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      chk({tag, "_beat"}, g, e);
    end
    got_q.delete();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_dac_en"},    dac_en, 0);
    chk({tag, "_dac_code"},  dac_code, 0);
    chk({tag, "_valid"},     stream_if.out_valid, 0);
    chk({tag, "_data"},      stream_if.out_data, 0);
    chk({tag, "_row"},       stream_if.out_row, 0);
    chk({tag, "_col"},       stream_if.out_col, 0);
    chk({tag, "_last"},      stream_if.out_last, 0);
    chk({tag, "_frame"},     frame_id, 0);
    chk({tag, "_overflow"},  overflow, 0);
    chk({tag, "_proto"},     proto_err, 0);
    chk({tag, "_state"},     dbg_state, CAP_WAIT);
  endtask

  initial begin
    stream_if.out_ready = 1'b1;

    // Reset values
    step(2);
    chk_idle_outputs("reset");
    chk("reset_phase", dbg_phase, IDLE);
    reset = 1'b0;

    // Normal frame with latency check
    erase_pulse();
    chk("frame_inc", frame_id, 1);
    expose = 1'b1; step(2); expose = 1'b0;
    convert = 1'b1; step(3); convert = 1'b0; step(1);
    pix_data = 16'h2211;
    read1 = 1'b1;
    step(2);
    chk("lat_not_yet", stream_if.out_valid, 0);
    step(1);
    chk("lat_valid", stream_if.out_valid, 1);
    chk("lat_data", stream_if.out_data, 8'h11);
    chk("lat_col", stream_if.out_col, 0);
    step(c_read - 3);
    read1 = 1'b0;
    step(1);
    read_pulse(1'b1, 16'h4433, c_read);
    step(4);
    exp_q.push_back(beat(0, 0, 0, 8'h11));
    exp_q.push_back(beat(0, 1, 0, 8'h22));
    exp_q.push_back(beat(1, 0, 0, 8'h33));
    exp_q.push_back(beat(1, 1, 1, 8'h44));
    chk_stream("normal");
    chk("normal_proto", proto_err, 0);
    chk("normal_ovf", overflow, 0);

    // Ramp count, saturation and return to zero
    convert = 1'b1;
    chk("ramp_phase", dbg_phase, CONVERT);
    chk("ramp_en_delay", dac_en, 0);
    for (int k = 1; k <= 300; k++) begin
      step(1);
      chk("ramp_code", dac_code, (k - 1 > c_convert) ? c_convert : k - 1);
      chk("ramp_en", dac_en, 1);
    end
    convert = 1'b0;
    step(1);
    chk("ramp_end_code", dac_code, 0);
    chk("ramp_end_en", dac_en, 0);

    // Stalled sink: two rows held, third capture dropped
    do_reset();
    stream_if.out_ready = 1'b0;
    read_pulse(1'b0, 16'hBBAA, c_read);
    read_pulse(1'b1, 16'hDDCC, c_read);
    chk("stall_hold_data", stream_if.out_data, 8'hAA);
    chk("stall_ovf_pre", overflow, 0);
    erase_pulse();
    chk("stall_frame", frame_id, 1);
    read_pulse(1'b0, 16'hFFEE, c_read);
    chk("stall_ovf", overflow, 1);
    chk("stall_valid", stream_if.out_valid, 1);
    chk("stall_data", stream_if.out_data, 8'hAA);
    chk("stall_row", stream_if.out_row, 0);
    chk("stall_col", stream_if.out_col, 0);
    stream_if.out_ready = 1'b1;
    step(10);
    exp_q.push_back(beat(0, 0, 0, 8'hAA));
    exp_q.push_back(beat(0, 1, 0, 8'hBB));
    exp_q.push_back(beat(1, 0, 0, 8'hCC));
    exp_q.push_back(beat(1, 1, 1, 8'hDD));
    chk_stream("stall");
    chk("stall_ovf_sticky", overflow, 1);

    // read1 and read2 together
    do_reset();
    chk("both_ovf_cleared", overflow, 0);
    pix_data = 16'h5A5A;
    read1 = 1'b1;
    read2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("both_no_valid", stream_if.out_valid, 0);
    end
    chk("both_state", dbg_state, CAP_HOLD);
    read1 = 1'b0;
    read2 = 1'b0;
    step(3);
    chk("both_proto", proto_err, 1);
    chk("both_back_wait", dbg_state, CAP_WAIT);
    chk_stream("both");

    // Read pulse shorter than the sample point
    do_reset();
    pix_data = 16'h1234;
    read1 = 1'b1;
    step(1);
    chk("short_counting", dbg_state, CAP_COUNT);
    read1 = 1'b0;
    step(1);
    chk("short_proto", proto_err, 1);
    chk("short_state", dbg_state, CAP_WAIT);
    step(4);
    chk("short_no_valid", stream_if.out_valid, 0);
    chk("short_ovf", overflow, 0);
    chk_stream("short");

    // Asynchronous reset mid-drain, then a clean frame
    do_reset();
    erase_pulse();
    pix_data = 16'h5566;
    read1 = 1'b1;
    step(3);
    chk("mid_first", stream_if.out_data, 8'h66);
    step(1);
    chk("mid_second_col", stream_if.out_col, 1);
    chk("mid_second_data", stream_if.out_data, 8'h55);
    #1;
    reset = 1'b1;
    read1 = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    step(2);
    reset = 1'b0;
    got_q.delete();
    read_pulse(1'b0, 16'h7788, c_read);
    read_pulse(1'b1, 16'h99AA, c_read);
    step(4);
    exp_q.push_back(beat(0, 0, 0, 8'h88));
    exp_q.push_back(beat(0, 1, 0, 8'h77));
    exp_q.push_back(beat(1, 0, 0, 8'hAA));
    exp_q.push_back(beat(1, 1, 1, 8'h99));
    chk_stream("after_reset");

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
